// File: rtl/dice_roll_scheduler.sv
// dice_roll_scheduler: round-robin arbiter that shares one DiceRoller among
// NUM_REQ requesters. It issues a roll, waits ROLL_LATENCY edges, captures the
// value and range-checks it, then returns the result under valid/ready.
module dice_roll_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ID_W         = 2,
  parameter int unsigned ROLL_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_die,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 roll,
  output logic [1:0]           die_select,
  input  logic [7:0]           rolled_number,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [ID_W-1:0]      result_id,
  output logic [7:0]           result_value,
  output logic                 result_err,
  output logic                 busy,
  output logic [15:0]          roll_count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned VAL_W = 8;
  localparam int unsigned RC_W  = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [1:0]       die_q, die_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic             err_q, err_d;
  logic [RC_W-1:0]  roll_count_q, roll_count_d;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [1:0]       win_die;

  // Face count of each die code.
  function automatic logic [VAL_W-1:0] sides(input logic [1:0] die);
    case (die)
      2'b00:   sides = VAL_W'(4);
      2'b01:   sides = VAL_W'(6);
      2'b10:   sides = VAL_W'(8);
      default: sides = VAL_W'(20);
    endcase
  endfunction

  // Round-robin search starting just after the last winner, then fetch its die code.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_die   = 2'b00;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!win_found && req_valid[ID_W'((32'(ptr_q) + i) % NUM_REQ)]) begin
        win_found = 1'b1;
        win_id    = ID_W'((32'(ptr_q) + i) % NUM_REQ);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (win_id == ID_W'(j)) begin
        win_die = req_die[2*j +: 2];
      end
    end
  end

  // Next-state and datapath update for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    die_d        = die_q;
    wait_cnt_d   = wait_cnt_q;
    value_d      = value_q;
    err_d        = err_q;
    roll_count_d = roll_count_q;
    req_ready    = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready = NUM_REQ'(1) << win_id;
          id_d      = win_id;
          die_d     = win_die;
          ptr_d     = win_id;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = CNT_W'(ROLL_LATENCY);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - CNT_W'(1);
        if (wait_cnt_q == CNT_W'(1)) begin
          value_d      = rolled_number;
          err_d        = (rolled_number == '0) || (rolled_number > sides(die_q));
          roll_count_d = roll_count_q + RC_W'(1);
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      die_q        <= 2'b00;
      wait_cnt_q   <= '0;
      value_q      <= '0;
      err_q        <= 1'b0;
      roll_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      die_q        <= die_d;
      wait_cnt_q   <= wait_cnt_d;
      value_q      <= value_d;
      err_q        <= err_d;
      roll_count_q <= roll_count_d;
    end
  end

  // Outputs decoded directly from registered state.
  always_comb begin
    roll         = (state_q == S_ISSUE);
    die_select   = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? die_q : 2'b00;
    result_valid = (state_q == S_RESP);
    result_id    = id_q;
    result_value = value_q;
    result_err   = err_q;
    busy         = (state_q != S_IDLE);
    roll_count   = roll_count_q;
  end

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Self-checking bench for dice_roll_scheduler with a programmable DiceRoller stub.
module tb_dice_roll_scheduler;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned LAT = 1;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_die;
  logic [N-1:0]   req_ready;
  logic           roll;
  logic [1:0]     die_select;
  logic [7:0]     rolled_number;
  logic           result_valid;
  logic           result_ready;
  logic [IDW-1:0] result_id;
  logic [7:0]     result_value;
  logic           result_err;
  logic           busy;
  logic [15:0]    roll_count;

  dice_roll_scheduler #(.NUM_REQ(N), .ID_W(IDW), .ROLL_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_die(req_die),
    .req_ready(req_ready), .roll(roll), .die_select(die_select),
    .rolled_number(rolled_number), .result_valid(result_valid),
    .result_ready(result_ready), .result_id(result_id),
    .result_value(result_value), .result_err(result_err), .busy(busy),
    .roll_count(roll_count)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          ptr_m;
  logic [15:0] roll_m;
  int          sides_tab [4] = '{4, 6, 8, 20};

  typedef struct {
    logic [N-1:0]   rv;
    logic [2*N-1:0] die;
    logic [7:0]     stub;
    int             exp_id;
    logic [7:0]     exp_val;
    logic           exp_err;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Round-robin rule: first pending requester after the previous winner.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 1; i <= int'(N); i++) begin
      int idx;
      idx = (p + i) % int'(N);
      if (v[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  function automatic logic exp_err(input logic [1:0] d, input logic [7:0] v);
    return (v == 8'd0) || (int'(v) > sides_tab[d]);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset  = 1'b0;
    ptr_m  = int'(N) - 1;
    roll_m = 16'd0;
  endtask

  // Entered and left at a drive point (1 time unit after a rising edge).
  task automatic chk_reset_outputs(input string t);
    @(negedge clock);
    chk({t, "_req_ready"},    32'(req_ready), 32'd0);
    chk({t, "_roll"},         32'(roll), 32'd0);
    chk({t, "_die_select"},   32'(die_select), 32'd0);
    chk({t, "_result_valid"}, 32'(result_valid), 32'd0);
    chk({t, "_result_id"},    32'(result_id), 32'd0);
    chk({t, "_result_value"}, 32'(result_value), 32'd0);
    chk({t, "_result_err"},   32'(result_err), 32'd0);
    chk({t, "_busy"},         32'(busy), 32'd0);
    chk({t, "_roll_count"},   32'(roll_count), 32'd0);
    @(posedge clock); #1;
  endtask

  // One full transaction from IDLE; the winner drops its request after accept.
  task automatic run_txn(input int hold, output int gid, output logic [7:0] gval, output logic gerr);
    int         w;
    int         n;
    logic [1:0] d;
    logic [7:0] v;
    logic       e;
    gid  = -1;
    gval = 8'd0;
    gerr = 1'b0;
    @(negedge clock);
    chk("idle_valid_low", 32'(result_valid), 32'd0);
    w = pick(req_valid, ptr_m);
    if (w < 0) begin
      chk("no_req_ready", 32'(req_ready), 32'd0);
      chk("no_req_busy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      return;
    end
    d = 2'(req_die >> (2 * w));
    v = rolled_number;
    e = exp_err(d, v);
    chk("req_ready", 32'(req_ready), 32'(1) << w);
    @(posedge clock); #1;
    req_valid = req_valid & ~(N'(1) << w);
    ptr_m = w;
    @(negedge clock);
    chk("roll_pulse", 32'(roll), 32'd1);
    chk("die_select", 32'(die_select), 32'(d));
    n = 1;
    while (!result_valid && n < 40) begin
      @(posedge clock); #1;
      n++;
      @(negedge clock);
    end
    chk("latency", 32'(n), 32'(LAT + 2));
    if (!result_valid) return;
    roll_m = roll_m + 16'd1;
    gid  = int'(result_id);
    gval = result_value;
    gerr = result_err;
    chk("result_id", 32'(result_id), 32'(w));
    chk("result_value", 32'(result_value), 32'(v));
    chk("result_err", 32'(result_err), 32'(e));
    chk("roll_count", 32'(roll_count), 32'(roll_m));
    chk("resp_roll_low", 32'(roll), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk("hold_valid", 32'(result_valid), 32'd1);
      chk("hold_id", 32'(result_id), 32'(w));
      chk("hold_value", 32'(result_value), 32'(v));
      chk("hold_err", 32'(result_err), 32'(e));
      chk("hold_no_grant", 32'(req_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    result_ready = 1'b1;
    @(posedge clock); #1;
    result_ready = 1'b0;
  endtask

  initial begin
    int         gid;
    logic [7:0] gval;
    logic       gerr;

    tbl[0] = '{4'b0100, 8'b00_01_00_00, 8'd5,  2, 8'd5,  1'b0};
    tbl[1] = '{4'b0001, 8'b00_00_00_00, 8'd7,  0, 8'd7,  1'b1};
    tbl[2] = '{4'b1000, 8'b11_00_00_00, 8'd20, 3, 8'd20, 1'b0};
    tbl[3] = '{4'b0010, 8'b00_00_10_00, 8'd0,  1, 8'd0,  1'b1};
    tbl[4] = '{4'b1111, 8'b10_10_10_10, 8'd8,  2, 8'd8,  1'b0};
    tbl[5] = '{4'b1011, 8'b10_10_10_10, 8'd9,  3, 8'd9,  1'b1};
    tbl[6] = '{4'b0110, 8'b01_01_01_01, 8'd6,  1, 8'd6,  1'b0};

    reset         = 1'b1;
    req_valid     = '0;
    req_die       = '0;
    rolled_number = 8'd0;
    result_ready  = 1'b0;

    do_reset();
    chk_reset_outputs("reset");

    // Directed vectors: single request, range checks, round-robin order.
    for (int i = 0; i < 7; i++) begin
      req_valid     = tbl[i].rv;
      req_die       = tbl[i].die;
      rolled_number = tbl[i].stub;
      run_txn(0, gid, gval, gerr);
      req_valid = '0;
      chk("tbl_id", 32'(gid), 32'(tbl[i].exp_id));
      chk("tbl_value", 32'(gval), 32'(tbl[i].exp_val));
      chk("tbl_err", 32'(gerr), 32'(tbl[i].exp_err));
    end

    // Contention from reset: grants 0,1,2,3 then wrap back to 0.
    do_reset();
    req_die       = 8'b01_01_01_01;
    rolled_number = 8'd3;
    req_valid     = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      run_txn(0, gid, gval, gerr);
      chk("rr_order", 32'(gid), 32'(i));
    end
    req_valid = 4'b1111;
    run_txn(0, gid, gval, gerr);
    chk("rr_wrap", 32'(gid), 32'd0);
    req_valid = '0;

    // Backpressure with a competing request, then the next grant follows.
    req_valid     = 4'b0101;
    req_die       = 8'b00_11_00_10;
    rolled_number = 8'd4;
    run_txn(10, gid, gval, gerr);
    chk("bp_first", 32'(gid), 32'd2);
    run_txn(0, gid, gval, gerr);
    chk("bp_next", 32'(gid), 32'd0);
    req_valid = '0;

    // Reset while WAIT is in flight.
    do_reset();
    req_valid     = 4'b0010;
    req_die       = 8'b00_00_01_00;
    rolled_number = 8'd2;
    @(negedge clock);
    chk("mid_grant", 32'(req_ready), 32'b0010);
    @(posedge clock); #1;
    req_valid = '0;
    @(posedge clock); #1;
    chk("mid_in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset  = 1'b0;
    ptr_m  = int'(N) - 1;
    roll_m = 16'd0;
    chk_reset_outputs("midreset");
    req_valid = 4'b1111;
    run_txn(0, gid, gval, gerr);
    chk("mid_next_winner", 32'(gid), 32'd0);
    req_valid = '0;

    // Randomized traffic against the reference model.
    do_reset();
    for (int it = 0; it < 60; it++) begin
      for (int r = 0; r < int'(N); r++) begin
        if (!req_valid[2'(r)] && ($urandom_range(0, 1) == 1)) begin
          req_valid[2'(r)]     = 1'b1;
          req_die[3'(2*r) +: 2] = 2'($urandom_range(0, 3));
        end
      end
      rolled_number = 8'($urandom_range(0, 24));
      run_txn(int'($urandom_range(0, 3)), gid, gval, gerr);
    end
    req_valid = '0;

    // Counter wrap: preload 16'hFFFF, next roll must give 0.
    @(negedge clock);
    @(posedge clock); #1;
    force dut.roll_count_q = 16'hFFFF;
    @(posedge clock); #1;
    release dut.roll_count_q;
    roll_m        = 16'hFFFF;
    req_valid     = 4'b0001;
    req_die       = 8'b00_00_00_11;
    rolled_number = 8'd13;
    run_txn(0, gid, gval, gerr);
    @(negedge clock);
    chk("wrap_zero", 32'(roll_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
